// File: rtl/alu_pkg.sv
// Shared ALU constants: default widths, opcodes, loader FSM states.
// Imported by alu, btn_edge and alu_operand_loader.
package alu_pkg;

  localparam int NB_DATA_DEF = 6;
  localparam int NB_OP_DEF   = 6;

  localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;
  localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    SHOW    = 2'd3
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: operands are sign-extended to NB_DATA+1 bits.
// Unknown opcodes yield zero.
module alu
  import alu_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF
) (
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  input  logic [NB_OP-1:0]   i_op,
  output logic [NB_DATA:0]   o_result
);

  logic signed [NB_DATA:0] ext_a;
  logic signed [NB_DATA:0] ext_b;

  assign ext_a = {i_data_a[NB_DATA-1], i_data_a};
  assign ext_b = {i_data_b[NB_DATA-1], i_data_b};

  // Opcode decode and result select
  always_comb begin
    o_result = '0;
    case (i_op)
      NB_OP'(OP_ADD): o_result = ext_a + ext_b;
      NB_OP'(OP_SUB): o_result = ext_a - ext_b;
      NB_OP'(OP_AND): o_result = ext_a & ext_b;
      NB_OP'(OP_OR):  o_result = ext_a | ext_b;
      NB_OP'(OP_XOR): o_result = ext_a ^ ext_b;
      NB_OP'(OP_NOR): o_result = ~(ext_a | ext_b);
      NB_OP'(OP_SRA): o_result = ext_a >>> i_data_b;
      NB_OP'(OP_SRL): o_result = {1'b0, i_data_a} >> i_data_b;
      default:        o_result = '0;
    endcase
  end

endmodule

// File: rtl/btn_edge.sv
// Button conditioner: 2-FF sync, optional debounce, rising-edge pulse.
// Debounce filter is built when ALU_LOADER_DEBOUNCE_EN is defined.
module btn_edge #(
  parameter int DB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_pulse
);

  logic sync_1;
  logic sync_2;
  logic level;
  logic level_q;

  // Two-stage synchronizer for the asynchronous button level
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= i_btn;
      sync_2 <= sync_1;
    end
  end

`ifdef ALU_LOADER_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] db_cnt;
  logic          db_level;

  // Filtered level follows sync only after DB_CYCLES stable clocks
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (sync_2 == db_level) begin
      db_cnt   <= '0;
    end else if (db_cnt == CW'(DB_CYCLES - 1)) begin
      db_cnt   <= '0;
      db_level <= sync_2;
    end else begin
      db_cnt   <= db_cnt + 1'b1;
    end
  end

  assign level = db_level;
`else
  assign level = sync_2;
`endif

  // Previous level for rising-edge detection
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign o_pulse = level & ~level_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Loads A, B and opcode from a shared switch bus and shows the ALU result.
// Optional button debounce: define ALU_LOADER_DEBOUNCE_EN.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int NB_DATA   = NB_DATA_DEF,
  parameter int NB_OP     = NB_OP_DEF,
  parameter int DB_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_sw,
  input  logic               i_btn_a,
  input  logic               i_btn_b,
  input  logic               i_btn_op,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA:0]   o_led,
  output logic               o_valid,
  output logic               o_err,
  output logic [1:0]         o_state
);

  state_t state;
  state_t state_nxt;

  logic pulse_a;
  logic pulse_b;
  logic pulse_op;
  logic cap_a;
  logic cap_b;
  logic cap_op;
  logic load_res;
  logic op_ok;

  logic [NB_DATA:0] alu_res;

  btn_edge #(.DB_CYCLES(DB_CYCLES)) u_btn_a (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_a),
    .o_pulse (pulse_a)
  );

  btn_edge #(.DB_CYCLES(DB_CYCLES)) u_btn_b (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_b),
    .o_pulse (pulse_b)
  );

  btn_edge #(.DB_CYCLES(DB_CYCLES)) u_btn_op (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_op),
    .o_pulse (pulse_op)
  );

  alu #(
    .NB_DATA (NB_DATA),
    .NB_OP   (NB_OP)
  ) u_alu (
    .i_data_a (o_data_a),
    .i_data_b (o_data_b),
    .i_op     (o_op),
    .o_result (alu_res)
  );

  // Opcode legality check against the shared opcode set
  always_comb begin
    op_ok = 1'b0;
    case (o_op)
      NB_OP'(OP_ADD),
      NB_OP'(OP_SUB),
      NB_OP'(OP_AND),
      NB_OP'(OP_OR),
      NB_OP'(OP_XOR),
      NB_OP'(OP_SRA),
      NB_OP'(OP_SRL),
      NB_OP'(OP_NOR): op_ok = 1'b1;
      default:        op_ok = 1'b0;
    endcase
  end

  // Next state and capture strobes; mismatched pulses are dropped
  always_comb begin
    state_nxt = state;
    cap_a     = 1'b0;
    cap_b     = 1'b0;
    cap_op    = 1'b0;
    unique case (state)
      WAIT_A: begin
        if (pulse_a) begin
          cap_a     = 1'b1;
          state_nxt = WAIT_B;
        end
      end
      WAIT_B: begin
        if (pulse_b) begin
          cap_b     = 1'b1;
          state_nxt = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (pulse_op) begin
          cap_op    = 1'b1;
          state_nxt = SHOW;
        end
      end
      SHOW: begin
        if (pulse_a) begin
          cap_a     = 1'b1;
          state_nxt = WAIT_B;
        end
      end
      default: state_nxt = WAIT_A;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= WAIT_A;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture and result register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_data_a <= '0;
      o_data_b <= '0;
      o_op     <= '0;
      o_led    <= '0;
      o_valid  <= 1'b0;
      o_err    <= 1'b0;
      load_res <= 1'b0;
    end else begin
      load_res <= cap_op;
      if (cap_a) begin
        o_data_a <= i_sw;
      end
      if (cap_b) begin
        o_data_b <= i_sw;
      end
      if (cap_op) begin
        o_op <= i_sw[NB_OP-1:0];
      end
      if (cap_a) begin
        o_valid <= 1'b0;
        o_err   <= 1'b0;
      end else if (load_res) begin
        o_led   <= op_ok ? alu_res : '0;
        o_err   <= ~op_ok;
        o_valid <= 1'b1;
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader: vector table plus
// hand sequences for ordering, latency, reset and debounce.
module tb_alu_operand_loader;
  import alu_pkg::*;

`ifdef ALU_LOADER_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif
  localparam int LAT  = 4 + DB;
  localparam int HOLD = 2 + DB;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [5:0] i_sw;
  logic       i_btn_a;
  logic       i_btn_b;
  logic       i_btn_op;
  logic [5:0] o_data_a;
  logic [5:0] o_data_b;
  logic [5:0] o_op;
  logic [6:0] o_led;
  logic       o_valid;
  logic       o_err;
  logic [1:0] o_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] op;
    logic [6:0] led;
    logic       err;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  alu_operand_loader #(
    .NB_DATA   (6),
    .NB_OP     (6),
    .DB_CYCLES (4)
  ) dut (
    .i_clk    (clk),
    .i_reset  (i_reset),
    .i_sw     (i_sw),
    .i_btn_a  (i_btn_a),
    .i_btn_b  (i_btn_b),
    .i_btn_op (i_btn_op),
    .o_data_a (o_data_a),
    .o_data_b (o_data_b),
    .o_op     (o_op),
    .o_led    (o_led),
    .o_valid  (o_valid),
    .o_err    (o_err),
    .o_state  (o_state)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // m = {op, b, a} buttons pressed together
  task automatic press(input logic [2:0] m,
                       input logic [5:0] sw,
                       input int hold);
    @(negedge clk);
    i_sw = sw;
    {i_btn_op, i_btn_b, i_btn_a} = m;
    repeat (hold) @(negedge clk);
    {i_btn_op, i_btn_b, i_btn_a} = 3'b000;
    repeat (LAT + 2) @(negedge clk);
    i_sw = 6'h2a;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " st"},  32'(o_state),  0);
    chk({nm, " a"},   32'(o_data_a), 0);
    chk({nm, " b"},   32'(o_data_b), 0);
    chk({nm, " op"},  32'(o_op),     0);
    chk({nm, " led"}, 32'(o_led),    0);
    chk({nm, " vld"}, 32'(o_valid),  0);
    chk({nm, " err"}, 32'(o_err),    0);
  endtask

  initial begin
    vecs[0]  = '{6'd5,     6'd3,     OP_ADD, 7'h08, 1'b0};
    vecs[1]  = '{6'd5,     6'd3,     OP_SUB, 7'h02, 1'b0};
    vecs[2]  = '{6'b100100, 6'd1,    OP_SRA, 7'h72, 1'b0};
    vecs[3]  = '{6'd5,     6'd3,     OP_AND, 7'h01, 1'b0};
    vecs[4]  = '{6'd5,     6'd3,     OP_OR,  7'h07, 1'b0};
    vecs[5]  = '{6'd5,     6'd3,     OP_XOR, 7'h06, 1'b0};
    vecs[6]  = '{6'd5,     6'd3,     OP_NOR, 7'h78, 1'b0};
    vecs[7]  = '{6'b100100, 6'd2,    OP_SRL, 7'h09, 1'b0};
    vecs[8]  = '{6'b011111, 6'd1,    OP_ADD, 7'h20, 1'b0};
    vecs[9]  = '{6'b100000, 6'b011111, OP_SUB, 7'h41, 1'b0};
    vecs[10] = '{6'd5,     6'd3,     6'b111111, 7'h00, 1'b1};

    i_reset  = 1'b1;
    i_sw     = '0;
    i_btn_a  = 1'b0;
    i_btn_b  = 1'b0;
    i_btn_op = 1'b0;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    chk_zero("rst");

    // out-of-order pulses in WAIT_A
    press(3'b010, 6'd3, HOLD);
    press(3'b100, OP_ADD, HOLD);
    chk("ord st", 32'(o_state),  0);
    chk("ord b",  32'(o_data_b), 0);
    chk("ord op", 32'(o_op),     0);
    press(3'b001, 6'd5, HOLD);
    chk("ord a1 st", 32'(o_state),  1);
    chk("ord a1",    32'(o_data_a), 5);
    press(3'b001, 6'd9, HOLD);
    chk("ord a2 st", 32'(o_state),  1);
    chk("ord a2",    32'(o_data_a), 5);

    // all three buttons at once in WAIT_B: only B acts
    press(3'b111, 6'd3, HOLD);
    chk("sim st", 32'(o_state),  2);
    chk("sim a",  32'(o_data_a), 5);
    chk("sim b",  32'(o_data_b), 3);
    chk("sim op", 32'(o_op),     0);

    // op latency: valid exactly LAT edges after button
    @(negedge clk);
    i_sw = OP_ADD;
    i_btn_op = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk("lat st",   32'(o_state), 3);
    chk("lat vld0", 32'(o_valid), 0);
    @(posedge clk);
    #1;
    chk("lat vld1", 32'(o_valid), 1);
    chk("lat led",  32'(o_led),   8);
    chk("lat err",  32'(o_err),   0);
    @(negedge clk);
    i_btn_op = 1'b0;
    repeat (LAT + 2) @(negedge clk);

    // new A in SHOW clears valid, keeps old LED value
    press(3'b001, 6'd7, HOLD);
    chk("show a st",  32'(o_state),  1);
    chk("show a vld", 32'(o_valid),  0);
    chk("show a led", 32'(o_led),    8);
    chk("show a",     32'(o_data_a), 7);

    do_reset();
    for (int i = 0; i < 11; i++) begin
      press(3'b001, vecs[i].a,  HOLD);
      press(3'b010, vecs[i].b,  HOLD);
      press(3'b100, vecs[i].op, HOLD);
      chk($sformatf("v%0d led", i), 32'(o_led),    32'(vecs[i].led));
      chk($sformatf("v%0d err", i), 32'(o_err),    32'(vecs[i].err));
      chk($sformatf("v%0d vld", i), 32'(o_valid),  1);
      chk($sformatf("v%0d st", i),  32'(o_state),  3);
      chk($sformatf("v%0d a", i),   32'(o_data_a), 32'(vecs[i].a));
      chk($sformatf("v%0d b", i),   32'(o_data_b), 32'(vecs[i].b));
      chk($sformatf("v%0d op", i),  32'(o_op),     32'(vecs[i].op));
    end

    // leave SHOW after an illegal op
    press(3'b001, 6'd4, HOLD);
    chk("ill a vld", 32'(o_valid), 0);
    chk("ill a err", 32'(o_err),   0);
    chk("ill a st",  32'(o_state), 1);
    chk("ill a led", 32'(o_led),   0);

    // reset in WAIT_OP
    do_reset();
    press(3'b001, 6'd5, HOLD);
    press(3'b010, 6'd3, HOLD);
    chk("mid st", 32'(o_state), 2);
    @(negedge clk);
    i_reset = 1'b1;
    #1;
    chk("mid async st", 32'(o_state),  0);
    chk("mid async a",  32'(o_data_a), 0);
    @(negedge clk);
    i_reset = 1'b0;
    chk_zero("mid");
    press(3'b100, OP_ADD, HOLD);
    chk("mid op st", 32'(o_state), 0);
    chk("mid op",    32'(o_op),    0);
    chk("mid vld",   32'(o_valid), 0);

`ifdef ALU_LOADER_DEBOUNCE_EN
    press(3'b001, 6'd9, 3);
    chk("glitch st", 32'(o_state),  0);
    chk("glitch a",  32'(o_data_a), 0);
`endif

    // 6-cycle press: capture lands at edge 3+DB
    @(negedge clk);
    i_sw = 6'd9;
    i_btn_a = 1'b1;
    repeat (2 + DB) @(posedge clk);
    #1;
    chk("press6 early st", 32'(o_state),  0);
    chk("press6 early a",  32'(o_data_a), 0);
    while (DB + 2 < 6) begin
      break;
    end
    @(negedge clk);
    if (DB + 2 >= 6) i_btn_a = 1'b0;
    @(posedge clk);
    #1;
    chk("press6 st", 32'(o_state),  1);
    chk("press6 a",  32'(o_data_a), 9);
    @(negedge clk);
    i_btn_a = 1'b0;
    repeat (LAT + 2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Hardware counterpart of the ALU stimulus: a sequential front end that loads A, B and the opcode from one shared switch bus, one button per field.
- Drives the existing combinational `alu` and registers its result for display on LEDs.
- Sits between the board I/O (switches, buttons, LEDs) and the `alu` instance in the top level.

Parameters:
- NB_DATA, 6, operand width; the result is NB_DATA+1 bits.
- NB_OP, 6, opcode width; NB_OP <= NB_DATA is required.
- DB_CYCLES, 4, debounce stability length in clocks (used only with DEBOUNCE_EN).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_sw  in  NB_DATA  shared switch bus; the opcode is taken from i_sw[NB_OP-1:0]
- i_btn_a  in  1  load-A button, asynchronous level
- i_btn_b  in  1  load-B button, asynchronous level
- i_btn_op  in  1  load-opcode button, asynchronous level
- o_data_a  out  NB_DATA  registered operand A
- o_data_b  out  NB_DATA  registered operand B
- o_op  out  NB_OP  registered opcode
- o_led  out  NB_DATA+1  registered signed ALU result
- o_valid  out  1  o_led holds the result of the current A/B/OP set
- o_err  out  1  the last captured opcode is illegal
- o_state  out  2  FSM state, for LEDs and debug

Behaviour:
- Reset:
  - Reset is asynchronous and active-high; one clock, i_clk. All registers clear on i_reset.
  - Outputs after reset: o_data_a=0, o_data_b=0, o_op=0, o_led=0, o_valid=0, o_err=0, o_state=WAIT_A (2'd0).
- Button path:
  - Each button passes through a 2-FF synchronizer and then a rising-edge detector.
  - This produces a one-cycle pulse, high between clock edges 2 and 3 after the button is first sampled high.
  - A held button produces exactly one pulse.
- FSM states: WAIT_A=0, WAIT_B=1, WAIT_OP=2, SHOW=3.
  - WAIT_A: pulse_a -> o_data_a<=i_sw, go to WAIT_B.
  - WAIT_B: pulse_b -> o_data_b<=i_sw, go to WAIT_OP.
  - WAIT_OP: pulse_op -> o_op<=i_sw[NB_OP-1:0], go to SHOW.
  - Entry to SHOW (the cycle after the op capture): o_led <= alu result, or 0 if the opcode is illegal.
    - o_err <= the illegal flag.
    - o_valid <= 1.
  - SHOW: pulse_a -> capture A, o_valid<=0, o_err<=0, go to WAIT_B. o_led keeps the old value until the next result.
- Out-of-order pulses (for example pulse_b in WAIT_A, or pulse_op in WAIT_B) are ignored; no register changes.
- Simultaneous pulses: only the pulse matching the current state acts; the others are dropped, not queued.
- Latency: from button sampled high to o_valid=1 is 4 clock edges (sync 2, edge detect 1, result register 1).
- Opcodes:
  - Legal set: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111.
  - Any other value sets o_err=1 with o_led=0.
- Arithmetic: the result is the `alu` output, NB_DATA+1 bits, signed; the block adds no extension or truncation.
- Reset mid-sequence: the FSM returns to WAIT_A immediately, all captured fields clear, and a pending pulse is lost.
- i_sw changes: i_sw is sampled only on the capture cycle; changes at other times have no effect.

Optional Feature:
- Macro: ALU_LOADER_DEBOUNCE_EN.
- Defined: after the synchronizer, a per-button counter requires the synchronized level to be stable for DB_CYCLES consecutive clocks before the filtered level changes.
  - Glitches shorter than DB_CYCLES produce no pulse.
  - Latency grows by DB_CYCLES.
- Undefined: no filter; the synchronizer feeds the edge detector directly, and DB_CYCLES is unused.

Decomposition:
- Shared package alu_pkg holds:
  - NB_DATA and NB_OP defaults.
  - The opcode localparams OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR.
  - The FSM state encodings.
- The same opcode constants are used by `alu` and by the legality check.
- Sub-module btn_edge (sync, optional debounce, rising-edge pulse) is instantiated three times.
- The existing `alu` is instantiated unchanged.

Test Plan:
- Basic ADD: reset; i_sw=000101 + btn_a, i_sw=000011 + btn_b, i_sw=100000 + btn_op.
  - Expect o_led=0001000 (8) and o_valid=1 exactly 4 edges after btn_op, with o_state=3.
- SUB and SRA:
  - A=000101, B=000011, op 100010 -> o_led=0000010.
  - A=100100 (-28), B=000001, op 000011 -> o_led=-14 (1110010).
- Ordering: pulse btn_b and btn_op while in WAIT_A -> o_state stays 0 and o_data_b/o_op stay 0. Then btn_a, btn_a again -> second press ignored, o_data_a unchanged.
- Illegal opcode: op 111111 -> o_err=1, o_led=0, o_valid=1. A new btn_a in SHOW -> o_valid=0, o_err=0, o_state=1.
- Reset in WAIT_OP with A=5, B=3 loaded -> all outputs zero, o_state=0. Then btn_op -> no effect.
- With ALU_LOADER_DEBOUNCE_EN and DB_CYCLES=4:
  - A 3-cycle btn_a glitch -> no capture.
  - A 6-cycle press -> one capture, arriving DB_CYCLES later than without the macro.
